// File: rtl/microwave_timer_ctrl_pkg.sv
// Shared definitions for the microwave cook timer: FSM states and BCD digit limits.
package microwave_timer_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COOK  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [3:0] DIGIT_MAX = 4'd9;
  localparam logic [3:0] TENS_MAX  = 4'd5;
  localparam logic [3:0] MIN_MAX   = 4'd9;

  // True when a BCD digit does not exceed the given limit.
  function automatic logic bcd_le(input logic [3:0] d, input logic [3:0] lim);
    return d <= lim;
  endfunction

endpackage

// File: rtl/microwave_timer_ctrl_if.sv
// Keypad/control inputs and display/status outputs of the cook timer.
interface microwave_timer_ctrl_if;
  logic       key_valid;
  logic [3:0] key_digit;
  logic       start;
  logic       stop;
  logic       door_closed;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] min;
  logic       mag_on;
  logic       timer_done;
  logic [1:0] state;

  modport master (
    output key_valid, key_digit, start, stop, door_closed,
    input  sec_ones, sec_tens, min, mag_on, timer_done, state
  );

  modport slave (
    input  key_valid, key_digit, start, stop, door_closed,
    output sec_ones, sec_tens, min, mag_on, timer_done, state
  );
endinterface

// File: rtl/microwave_timer_ctrl_bcd_mmss_down.sv
// M:SS BCD time register: keypad shift-in, clear and one-second decrement.
module bcd_mmss_down
  import microwave_timer_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load_shift,
  input  logic [3:0] digit_in,
  input  logic       clear,
  input  logic       dec,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min,
  output logic       is_zero,
  output logic       next_is_zero
);

  logic [3:0] ones_q, ones_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] min_q,  min_d;

  // Next digit values: clear beats decrement beats shift-in.
  always_comb begin
    ones_d = ones_q;
    tens_d = tens_q;
    min_d  = min_q;
    if (clear) begin
      ones_d = '0;
      tens_d = '0;
      min_d  = '0;
    end else if (dec) begin
      if (ones_q != 4'd0) begin
        ones_d = ones_q - 4'd1;
      end else begin
        ones_d = DIGIT_MAX;
        if (tens_q != 4'd0) begin
          tens_d = tens_q - 4'd1;
        end else begin
          tens_d = TENS_MAX;
          if (min_q != 4'd0) begin
            min_d = min_q - 4'd1;
          end
        end
      end
    end else if (load_shift) begin
      min_d  = tens_q;
      tens_d = ones_q;
      ones_d = digit_in;
    end
  end

  // Digit registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ones_q <= '0;
      tens_q <= '0;
      min_q  <= '0;
    end else begin
      ones_q <= ones_d;
      tens_q <= tens_d;
      min_q  <= min_d;
    end
  end

  assign sec_ones     = ones_q;
  assign sec_tens     = tens_q;
  assign min          = min_q;
  assign is_zero      = (ones_q == 4'd0) && (tens_q == 4'd0) && (min_q == 4'd0);
  assign next_is_zero = (ones_q == 4'd1) && (tens_q == 4'd0) && (min_q == 4'd0);

endmodule

// File: rtl/microwave_timer_ctrl.sv
// Microwave cook timer: state machine, one-second prescaler and magnetron control.
module microwave_timer_ctrl
  import microwave_timer_ctrl_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 50_000_000
) (
  input  logic                   clk,
  input  logic                   reset,
  microwave_timer_ctrl_if.slave  bus
);

  localparam int unsigned PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          mag_on_q, mag_on_d;
  logic          timer_done_q, timer_done_d;

  logic          load_shift, clear, dec;
  logic          is_zero, next_is_zero;
  logic [3:0]    sec_ones, sec_tens, min;
  logic          tick, key_accept;

  bcd_mmss_down u_time (
    .clk          (clk),
    .reset        (reset),
    .load_shift   (load_shift),
    .digit_in     (bus.key_digit),
    .clear        (clear),
    .dec          (dec),
    .sec_ones     (sec_ones),
    .sec_tens     (sec_tens),
    .min          (min),
    .is_zero      (is_zero),
    .next_is_zero (next_is_zero)
  );

  assign tick = (presc_q == PRESC_LAST);

  // A key shifts in only if it is a digit and the shifted digits stay legal BCD.
  assign key_accept = bus.key_valid && bcd_le(bus.key_digit, DIGIT_MAX) &&
                      bcd_le(sec_ones, TENS_MAX) && bcd_le(sec_tens, MIN_MAX);

  // Next state, prescaler and time-register controls; priority stop > door > start > tick > key.
  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    load_shift = 1'b0;
    clear      = 1'b0;
    dec        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.stop) begin
          clear = 1'b1;
        end else if (bus.start && bus.door_closed && !is_zero) begin
          state_d = ST_COOK;
          presc_d = '0;
        end else if (key_accept) begin
          load_shift = 1'b1;
        end
      end
      ST_COOK: begin
        if (bus.stop || !bus.door_closed) begin
          state_d = ST_PAUSE;
        end else if (tick) begin
          presc_d = '0;
          dec     = 1'b1;
          if (next_is_zero) begin
            state_d = ST_DONE;
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      ST_PAUSE: begin
        if (bus.stop) begin
          state_d = ST_IDLE;
          clear   = 1'b1;
        end else if (bus.start && bus.door_closed) begin
          state_d = ST_COOK;
          presc_d = '0;
        end
      end
      ST_DONE: begin
        if (bus.stop || !bus.door_closed) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    mag_on_d     = (state_d == ST_COOK);
    timer_done_d = (state_d == ST_DONE);
  end

  // State, prescaler and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      presc_q      <= '0;
      mag_on_q     <= 1'b0;
      timer_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      mag_on_q     <= mag_on_d;
      timer_done_q <= timer_done_d;
    end
  end

  assign bus.sec_ones   = sec_ones;
  assign bus.sec_tens   = sec_tens;
  assign bus.min        = min;
  assign bus.mag_on     = mag_on_q;
  assign bus.timer_done = timer_done_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Self-checking bench for the microwave cook timer (TICKS_PER_SEC = 4).
module tb_microwave_timer_ctrl;

  logic clk = 1'b0;
  logic reset;

  microwave_timer_ctrl_if bus ();

  microwave_timer_ctrl #(.TICKS_PER_SEC(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] ones;
    logic [3:0] tens;
    logic [3:0] mins;
    logic       mag;
    logic       done;
    logic [1:0] st;
    string      tag;
  } exp_t;

  typedef struct {
    logic       kv;
    logic [3:0] kd;
    logic       st;
    logic       sp;
    logic       door;
    logic [3:0] e_min;
    logic [3:0] e_tens;
    logic [3:0] e_ones;
    logic [1:0] e_state;
    string      tag;
  } vec_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   drive_done = 1'b0;

  localparam logic [1:0] IDLE = 2'd0, COOK = 2'd1, PAUSE = 2'd2, DONE = 2'd3;

  // Drive one cycle of inputs at the falling edge and queue what the next rising edge must produce.
  task automatic cyc(input logic rst, input logic kv, input logic [3:0] kd,
                     input logic st, input logic sp, input logic door,
                     input logic [3:0] e_min, input logic [3:0] e_tens, input logic [3:0] e_ones,
                     input logic e_mag, input logic e_done, input logic [1:0] e_st,
                     input string tag);
    exp_t e;
    @(negedge clk);
    reset             = rst;
    bus.key_valid     = kv;
    bus.key_digit     = kd;
    bus.start         = st;
    bus.stop          = sp;
    bus.door_closed   = door;
    e.ones = e_ones; e.tens = e_tens; e.mins = e_min;
    e.mag  = e_mag;  e.done = e_done; e.st   = e_st;
    e.tag  = tag;
    q.push_back(e);
  endtask

  // Idle cycle with the door closed and no requests.
  task automatic nop(input logic [3:0] e_min, input logic [3:0] e_tens, input logic [3:0] e_ones,
                     input logic e_mag, input logic e_done, input logic [1:0] e_st, input string tag);
    cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, e_min, e_tens, e_ones, e_mag, e_done, e_st, tag);
  endtask

  task automatic key(input logic [3:0] d, input logic [3:0] e_min, input logic [3:0] e_tens,
                     input logic [3:0] e_ones, input string tag);
    cyc(1'b0, 1'b1, d, 1'b0, 1'b0, 1'b1, e_min, e_tens, e_ones, 1'b0, 1'b0, IDLE, tag);
  endtask

  // Compare the DUT against the oldest queued expectation just after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if ({bus.min, bus.sec_tens, bus.sec_ones, bus.mag_on, bus.timer_done, bus.state} !==
            {e.mins, e.tens, e.ones, e.mag, e.done, e.st}) begin
          errors++;
          $display("FAIL %s: got %0h:%0h%0h mag=%0b done=%0b st=%0d, want %0h:%0h%0h mag=%0b done=%0b st=%0d",
                   e.tag, bus.min, bus.sec_tens, bus.sec_ones, bus.mag_on, bus.timer_done, bus.state,
                   e.mins, e.tens, e.ones, e.mag, e.done, e.st);
        end
      end
    end
  end

  vec_t vt[$];

  initial begin
    vec_t v;
    reset = 1'b1;
    bus.key_valid = 1'b0; bus.key_digit = '0; bus.start = 1'b0;
    bus.stop = 1'b0; bus.door_closed = 1'b1;

    // Reset state
    cyc(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, IDLE, "reset");
    cyc(1'b1, 1'b1, 4'd7, 1'b1, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, IDLE, "reset_hold");

    // Keypad entry table: {kv, kd, start, stop, door, min, tens, ones, state}
    vt.push_back('{1'b1, 4'd1,  1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd1, IDLE, "key1"});
    vt.push_back('{1'b1, 4'd3,  1'b0, 1'b0, 1'b1, 4'd0, 4'd1, 4'd3, IDLE, "key3"});
    vt.push_back('{1'b1, 4'd0,  1'b0, 1'b0, 1'b1, 4'd1, 4'd3, 4'd0, IDLE, "key0_130"});
    vt.push_back('{1'b1, 4'd12, 1'b0, 1'b0, 1'b1, 4'd1, 4'd3, 4'd0, IDLE, "key12_ign"});
    vt.push_back('{1'b0, 4'd5,  1'b0, 1'b0, 1'b1, 4'd1, 4'd3, 4'd0, IDLE, "no_strobe"});
    vt.push_back('{1'b0, 4'd0,  1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 4'd0, IDLE, "stop_clr"});
    vt.push_back('{1'b1, 4'd0,  1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, IDLE, "key0"});
    vt.push_back('{1'b1, 4'd7,  1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd7, IDLE, "key7"});
    vt.push_back('{1'b1, 4'd2,  1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd7, IDLE, "key2_ign_gt5"});
    vt.push_back('{1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd7, IDLE, "start_door_open"});
    vt.push_back('{1'b1, 4'd4,  1'b1, 1'b1, 1'b1, 4'd0, 4'd0, 4'd0, IDLE, "stop_beats_start"});
    vt.push_back('{1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, IDLE, "start_at_zero"});
    foreach (vt[i]) begin
      v = vt[i];
      cyc(1'b0, v.kv, v.kd, v.st, v.sp, v.door, v.e_min, v.e_tens, v.e_ones,
          1'b0, 1'b0, v.e_state, v.tag);
    end

    // 0:02 countdown to DONE, then door open returns to IDLE
    key(4'd2, 4'd0, 4'd0, 4'd2, "k2");
    cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd0, 4'd0, 4'd2, 1'b1, 1'b0, COOK, "start_cook");
    for (int i = 0; i < 3; i++) nop(4'd0, 4'd0, 4'd2, 1'b1, 1'b0, COOK, "cook_002");
    nop(4'd0, 4'd0, 4'd1, 1'b1, 1'b0, COOK, "tick_001");
    for (int i = 0; i < 3; i++) nop(4'd0, 4'd0, 4'd1, 1'b1, 1'b0, COOK, "cook_001");
    nop(4'd0, 4'd0, 4'd0, 1'b0, 1'b1, DONE, "tick_done");
    cyc(1'b0, 1'b1, 4'd3, 1'b1, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, DONE, "done_ign_start_key");
    cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, IDLE, "done_door_idle");

    // 1:00 borrow, pause on door open, resume gives full second
    key(4'd1, 4'd0, 4'd0, 4'd1, "k1");
    key(4'd0, 4'd0, 4'd1, 4'd0, "k0");
    key(4'd0, 4'd1, 4'd0, 4'd0, "k0b");
    cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd1, 4'd0, 4'd0, 1'b1, 1'b0, COOK, "start_100");
    cyc(1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b1, 4'd1, 4'd0, 4'd0, 1'b1, 1'b0, COOK, "cook_key_ign");
    for (int i = 0; i < 2; i++) nop(4'd1, 4'd0, 4'd0, 1'b1, 1'b0, COOK, "cook_100");
    nop(4'd0, 4'd5, 4'd9, 1'b1, 1'b0, COOK, "tick_059");
    nop(4'd0, 4'd5, 4'd9, 1'b1, 1'b0, COOK, "cook_059");
    for (int i = 0; i < 20; i++)
      cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd5, 4'd9, 1'b0, 1'b0, PAUSE, "pause_hold");
    cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd0, 4'd5, 4'd9, 1'b1, 1'b0, COOK, "resume");
    for (int i = 0; i < 3; i++) nop(4'd0, 4'd5, 4'd9, 1'b1, 1'b0, COOK, "resume_059");
    nop(4'd0, 4'd5, 4'd8, 1'b1, 1'b0, COOK, "tick_058");
    cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd5, 4'd8, 1'b0, 1'b0, PAUSE, "stop_pause");
    cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, IDLE, "pause_startstop");

    // 0:45: tick coinciding with stop is discarded, then reset mid-cook
    key(4'd4, 4'd0, 4'd0, 4'd4, "k4");
    key(4'd5, 4'd0, 4'd4, 4'd5, "k5");
    cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd0, 4'd4, 4'd5, 1'b1, 1'b0, COOK, "start_045");
    for (int i = 0; i < 3; i++) nop(4'd0, 4'd4, 4'd5, 1'b1, 1'b0, COOK, "cook_045");
    cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd4, 4'd5, 1'b0, 1'b0, PAUSE, "tick_discard");
    cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd0, 4'd4, 4'd5, 1'b1, 1'b0, COOK, "resume_045");
    nop(4'd0, 4'd4, 4'd5, 1'b1, 1'b0, COOK, "cook_045b");
    cyc(1'b1, 1'b1, 4'd2, 1'b1, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, IDLE, "reset_mid_cook");
    nop(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, IDLE, "after_reset");

    drive_done = 1'b1;
  end

  // Finish once all expectations are consumed, bounded by a cycle budget.
  initial begin
    int n;
    wait (drive_done);
    n = 0;
    while (q.size() > 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #2;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no completion, want completion");
    $fatal(1, "timeout");
  end

endmodule
